// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a receive buffer, with sticky frame/overflow flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;

  logic                 sync1, sync2, rx_prev;
  logic [1:0]           settle;
  logic [DIV_WIDTH-1:0] div_eff, div_q, cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic                 start_edge, expire, pop;
  logic                 push, frame_set, ovf_set, wr_en;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  assign div_eff = (clk_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : clk_div;
  // settle masks the reset-forced high in the synchronizer so a line already low is not an edge
  assign start_edge = (settle == 2'd3) && rx_prev && !sync2;
  assign expire     = (cnt <= DIV_WIDTH'(1));
  assign pop        = rx_valid && rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= '0;
    end else begin
      sync1   <= ser_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = START;
      START:   if (expire) state_next = sync2 ? IDLE : DATA;
      DATA:    if (expire && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state == STOP && expire) begin
      push      = sync2;
      frame_set = !sync2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            div_q   <= div_eff;
            cnt     <= div_eff >> 1;
            bit_idx <= '0;
          end
        end
        START: begin
          if (expire) cnt <= div_q;
          else        cnt <= cnt - DIV_WIDTH'(1);
        end
        DATA: begin
          if (expire) begin
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= div_q;
          end else begin
            cnt <= cnt - DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (!expire) cnt <= cnt - DIV_WIDTH'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      count <= count + CNT_W'(1);
      else if (pop && !wr_en) count <= count - CNT_W'(1);
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign wr_en   = push && (!hold_valid || pop);
  assign ovf_set = push && hold_valid && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (wr_en) begin
      hold       <= shift;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign rx_valid = hold_valid;
  assign rx_data  = hold;
`endif

  // A set event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovf_set)      overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives serial frames cycle by cycle and checks against a queue model.
module tb_uart_rx_fifo;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ser_rx = 1'b1;
  logic [15:0] clk_div = 16'd16;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        frame_err;
  logic        overflow;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic exp_fe = 1'b0;
  logic exp_ovf = 1'b0;

  always #5 clock = ~clock;

  uart_rx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .ser_rx(ser_rx), .clk_div(clk_div),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr)
  );

  // Stop sample edge counted from the first cycle the line is driven low:
  // 2 synchronizer cycles, half a bit to mid-start, then 9 full bits.
  function automatic int stop_edge_of(input int raw_div);
    int d;
    d = (raw_div < 4) ? 4 : raw_div;
    return 2 + d / 2 + 9 * d;
  endfunction

  // stop_kind: 0 nothing, 1 good stop sample this edge (byte b), 2 bad stop sample this edge
  task automatic drive_cycle(input logic line, input logic rdy, input logic clr,
                             input logic rst, input int stop_kind, input logic [7:0] b);
    logic       popping;
    logic [7:0] head_seen;
    logic [7:0] want;
    logic       ovf_now;
    ser_rx = line; rx_ready = rdy; err_clr = clr; reset = rst;
    popping   = (rx_valid === 1'b1) && rdy;
    head_seen = rx_data;
    @(posedge clock); #1;
    if (rst) begin
      exp_q.delete();
      exp_fe  = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      if (popping) begin
        want = (exp_q.size() != 0) ? exp_q[0] : 8'hxx;
        checks++;
        if (exp_q.size() == 0 || head_seen !== want) begin
          errors++;
          $display("FAIL pop_data got %h want %h", head_seen, want);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (stop_kind == 2)  exp_fe = 1'b1;
      else if (clr)        exp_fe = 1'b0;
      ovf_now = 1'b0;
      if (stop_kind == 1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      ovf_now = 1'b1;
      end
      if (ovf_now)  exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
    checks++;
    if (rx_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL rx_valid got %b want %b at %0t", rx_valid, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (rx_data !== exp_q[0]) begin
        errors++;
        $display("FAIL rx_data got %h want %h at %0t", rx_data, exp_q[0], $time);
      end
    end
    checks++;
    if (frame_err !== exp_fe) begin
      errors++;
      $display("FAIL frame_err got %b want %b at %0t", frame_err, exp_fe, $time);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow got %b want %b at %0t", overflow, exp_ovf, $time);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, rdy, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // rdy_at/clr_at/rst_at/mid_div are cycle indices within the frame or values, -1 for unused
  task automatic send_frame(input logic [7:0] b, input logic stop_good, input int raw_div,
                            input logic always_rdy, input int rdy_at, input int clr_at,
                            input int rst_at, input int mid_div);
    int   div, stop_edge, len, sk;
    logic line, rst, aborted;
    clk_div   = 16'(raw_div);
    div       = (raw_div < 4) ? 4 : raw_div;
    stop_edge = stop_edge_of(raw_div);
    len       = (10 * div > stop_edge + 1) ? 10 * div : stop_edge + 1;
    aborted   = 1'b0;
    for (int i = 0; i < len; i++) begin
      int slot;
      slot = i / div;
      if (slot == 0)      line = 1'b0;
      else if (slot <= 8) line = b[slot-1];
      else if (slot == 9) line = stop_good;
      else                line = 1'b1;
      if (mid_div >= 0 && i == 4 * div) clk_div = 16'(mid_div);
      rst = (rst_at >= 0 && i >= rst_at && i < rst_at + 3);
      if (rst) aborted = 1'b1;
      sk = (i == stop_edge && !aborted) ? (stop_good ? 1 : 2) : 0;
      drive_cycle(line, always_rdy || i == rdy_at, i == clr_at, rst, sk, b);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h00);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    idle(8, 1'b0);
  endtask

  task automatic test_single_byte();
    send_frame(8'h55, 1'b1, 16, 1'b0, -1, -1, -1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h55 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_55 got v=%b d=%h fe=%b ov=%b want v=1 d=55 fe=0 ov=0",
               rx_valid, rx_data, frame_err, overflow);
    end
    idle(1, 1'b1);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_false_start();
    clk_div = 16'd16;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    idle(40, 1'b0);
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL false_start got v=%b fe=%b want v=0 fe=0", rx_valid, frame_err);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA3, 1'b0, 16, 1'b0, -1, -1, -1, -1);
    idle(2, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_set got fe=%b v=%b want fe=1 v=0", frame_err, rx_valid);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clr got %b want 0", frame_err);
    end
    send_frame(8'h5A, 1'b0, 16, 1'b0, -1, stop_edge_of(16), -1, -1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_set_wins got %b want 1", frame_err);
    end
    idle(2, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic test_overflow();
    for (int k = 0; k <= DEPTH; k++)
      send_frame(8'(k + 1), 1'b1, 16, 1'b0, -1, (k == DEPTH) ? stop_edge_of(16) : -1, -1, -1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %b want 1", overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'(k + 1)) begin
        errors++;
        $display("FAIL overflow_pop%0d got v=%b d=%h want v=1 d=%h", k, rx_valid, rx_data, 8'(k + 1));
      end
      idle(1, 1'b1);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained got v=%b want 0", rx_valid);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic test_full_pop_push();
    for (int k = 0; k < DEPTH; k++)
      send_frame(8'($urandom_range(0, 255)), 1'b1, 16, 1'b0, -1, -1, -1, -1);
    send_frame(8'h7E, 1'b1, 16, 1'b0, stop_edge_of(16), -1, -1, -1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_overflow got %b want 0", overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) begin
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
          errors++;
          $display("FAIL full_pop_last got v=%b d=%h want v=1 d=7e", rx_valid, rx_data);
        end
      end
      idle(1, 1'b1);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_drained got v=%b want 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      send_frame(8'($urandom_range(0, 255)), 1'b1, 16, 1'b1, -1, -1, -1, -1);
    idle(4, 1'b1);
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got v=%b fe=%b ov=%b want 0 0 0", rx_valid, frame_err, overflow);
    end
  endtask

  task automatic test_div_handling();
    send_frame(8'hC9, 1'b1, 20, 1'b1, -1, -1, -1, 7);
    send_frame(8'h36, 1'b1, 7, 1'b1, -1, -1, -1, -1);
    send_frame(8'hE1, 1'b1, 2, 1'b1, -1, -1, -1, -1);
    send_frame(8'h1E, 1'b1, 0, 1'b1, -1, -1, -1, -1);
    idle(4, 1'b1);
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL div_handling got v=%b fe=%b ov=%b want 0 0 0", rx_valid, frame_err, overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11, 1'b1, 16, 1'b0, -1, -1, -1, -1);
    send_frame(8'h22, 1'b0, 16, 1'b0, -1, -1, -1, -1);
    idle(2, 1'b0);
    send_frame(8'hC3, 1'b1, 16, 1'b0, -1, -1, 16 * 5 + 4, -1);
    idle(4, 1'b0);
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overflow !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_frame got v=%b fe=%b ov=%b d=%h want 0 0 0 00",
               rx_valid, frame_err, overflow, rx_data);
    end
    send_frame(8'h3C, 1'b1, 16, 1'b0, -1, -1, -1, -1);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL after_reset_3c got v=%b d=%h want v=1 d=3c", rx_valid, rx_data);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int   raw;
      logic good, rdy;
      raw  = $urandom_range(0, 24);
      good = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 1) != 0);
      send_frame(8'($urandom_range(0, 255)), good, raw, rdy, -1, -1, -1, -1);
      idle(2, 1'b0);
      repeat ($urandom_range(0, 2)) idle(1, 1'b1);
      if ($urandom_range(0, 2) == 0) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00);
    end
    idle(DEPTH + 2, 1'b1);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drained got v=%b want 0", rx_valid);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_div_handling();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, the bit width of clk_div.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ser_rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port clk_div, input, DIV_WIDTH, clock cycles per bit; values below 4 are treated as 4.
REQ-007 SHALL have port rx_data, output, 8, the byte at the FIFO head.
REQ-008 SHALL have port rx_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port rx_ready, input, 1, consumer pop; a pop occurs on a cycle with rx_valid&rx_ready.
REQ-010 SHALL have port frame_err, output, 1, sticky flag set when a stop bit is sampled low.
REQ-011 SHALL have port overflow, output, 1, sticky flag set when a byte is dropped on a full FIFO.
REQ-012 SHALL have port err_clr, input, 1, single-cycle clear of frame_err and overflow.

Function
REQ-013 SHALL pass ser_rx through a 2-flop synchronizer; all decoding uses the synchronized value (2-cycle input latency).
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 In IDLE, SHALL enter START on a synchronized high-to-low transition and load the bit counter with clk_div/2 (floor).
REQ-016 In START, when the counter expires SHALL sample the line: low -> DATA with counter=clk_div; high -> IDLE (false start, nothing pushed, no flag).
REQ-017 In DATA, SHALL sample once every clk_div cycles, shift LSB-first, and enter STOP after 8 samples; the bit index is 3 bits and wraps to 0.
REQ-018 In STOP, SHALL sample after clk_div cycles: high -> push the byte; low -> set frame_err and discard the byte; in both cases SHALL return to IDLE on the next cycle.
REQ-019 A returning IDLE SHALL accept a new start edge immediately, so back-to-back frames with one stop bit decode without loss.
REQ-020 A pushed byte SHALL appear on rx_data with rx_valid high on the cycle after the stop sample when the FIFO was empty.
REQ-021 rx_data SHALL be stable while rx_valid=1 and no pop occurs.
REQ-022 A push with the FIFO full and no simultaneous pop SHALL drop the new byte, set overflow, and leave FIFO contents unchanged.
REQ-023 A push and pop in the same cycle with the FIFO full SHALL succeed with no overflow; with the FIFO empty, only the push takes effect.
REQ-024 Pointers SHALL be log2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy counter.
REQ-025 If err_clr and a flag-setting event occur in the same cycle, SHALL leave the flag set (set wins).
REQ-026 clk_div SHALL be sampled at the start edge and held internally for the frame; changes mid-frame take effect on the next frame.

Reset
REQ-027 On reset SHALL go to IDLE, clear the counter, shift register, and pointers, and empty the FIFO.
REQ-028 On reset SHALL drive rx_valid=0, rx_data=0x00, frame_err=0, overflow=0, and synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no push and no flag; decoding resumes only on a fresh falling edge after reset deasserts.

Configuration
REQ-030 With macro UART_RX_FIFO_EN defined, SHALL implement the FIFO_DEPTH-entry FIFO as described.
REQ-031 Without UART_RX_FIFO_EN, SHALL replace the FIFO with a single holding register: depth 1, same ports, same overflow and pop rules, and FIFO_DEPTH ignored.

Verification
REQ-032 With clk_div=16, send 0x55 with a good stop bit -> rx_valid=1 and rx_data=0x55 on the cycle after the stop sample; no flags set.
REQ-033 Pull ser_rx low for 4 cycles with clk_div=16 -> no push, rx_valid stays 0, frame_err stays 0.
REQ-034 Send 0xA3 with stop bit low -> frame_err=1, no push; assert err_clr -> frame_err=0 on the next cycle.
REQ-035 With UART_RX_FIFO_EN and rx_ready=0, send 0x01..0x05 back-to-back -> overflow=1; popping returns 0x01,0x02,0x03,0x04 and then rx_valid=0.
REQ-036 With the FIFO full, hold rx_ready=1 during a stop-bit push of 0x7E -> overflow stays 0 and 0x7E is read last.
REQ-037 Assert reset during DATA bit 4 of 0xC3 -> rx_valid=0 and all flags 0 after reset; a subsequent 0x3C decodes correctly.
